// File: rtl/voice_allocator_if.sv
// Key/voice bundle between the key conditioners (master) and the voice allocator (slave).
interface voice_allocator_if #(
  parameter int unsigned NUM_VOICES = 2
);
  logic [7:0]              key;
  logic [NUM_VOICES-1:0]   speaker;
  logic [NUM_VOICES-1:0]   voice_active;
  logic [3*NUM_VOICES-1:0] voice_note;
  logic                    steal;

  modport master (output key, input speaker, voice_active, voice_note, steal);
  modport slave  (input key, output speaker, voice_active, voice_note, steal);
endinterface

// File: rtl/voice_allocator.sv
// Shares NUM_VOICES square-wave tone generators among eight keys, stealing the oldest
// voice when none is free.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned DIV_SHIFT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  voice_allocator_if.slave bus
);
  localparam int unsigned NV = NUM_VOICES;
  localparam int unsigned VW = (NV > 1) ? $clog2(NV) : 1;

  typedef enum logic [0:0] {StIdle, StAlloc} state_e;

  state_e        state_q, state_d;
  logic [7:0]    key_q, pending_q, pending_d, press, release_k;
  logic [NV-1:0] active_q, active_d, spk_q, spk_d;
  logic [NV-1:0] freed, alloc_oh, survive;
  logic [2:0]    note_q [NV];
  logic [2:0]    note_d [NV];
  logic [2:0]    rank_q [NV];
  logic [2:0]    rank_d [NV];
  logic [16:0]   cnt_q  [NV];
  logic [16:0]   cnt_d  [NV];
  logic          steal_q, steal_d;
  logic [2:0]    serve_key;
  logic          do_alloc, have_free;
  logic [VW-1:0] choice;

  function automatic logic [16:0] half_of(input logic [2:0] k);
    logic [16:0] t;
    case (k)
      3'd0:    t = 17'd95556;
      3'd1:    t = 17'd85131;
      3'd2:    t = 17'd75843;
      3'd3:    t = 17'd71586;
      3'd4:    t = 17'd63776;
      3'd5:    t = 17'd56818;
      3'd6:    t = 17'd50619;
      default: t = 17'd47778;
    endcase
    return t >> DIV_SHIFT;
  endfunction

  // Scheduler: serve the lowest pending key, one per edge.
  always_comb begin
    press     = bus.key & ~key_q;
    release_k = ~bus.key & key_q;
    serve_key = '0;
    for (int k = 7; k >= 0; k--) begin
      if (pending_q[k]) serve_key = 3'(k);
    end
    do_alloc  = (state_q == StAlloc) && !release_k[serve_key];
    pending_d = (pending_q | press) & ~release_k;
    if (state_q == StAlloc) pending_d[serve_key] = 1'b0;
    state_d   = (pending_d != '0) ? StAlloc : StIdle;
  end

  always_comb begin
    have_free = 1'b0;
    choice    = '0;
    for (int v = NV - 1; v >= 0; v--) begin
      if (!active_q[v]) begin
        have_free = 1'b1;
        choice    = VW'(v);
      end
    end
    if (!have_free) begin
      for (int v = 0; v < NV; v++) begin
        if (rank_q[v] == 3'(NV - 1)) choice = VW'(v);
      end
    end
    alloc_oh = '0;
    if (do_alloc) alloc_oh[choice] = 1'b1;
    for (int v = 0; v < NV; v++) freed[v] = active_q[v] & release_k[note_q[v]];
    survive  = active_q & ~freed & ~alloc_oh;
    active_d = survive | alloc_oh;
    steal_d  = do_alloc & ~have_free;

    for (int v = 0; v < NV; v++) begin
      note_d[v] = note_q[v];
      rank_d[v] = '0;
      cnt_d[v]  = '0;
      spk_d[v]  = 1'b0;
      if (alloc_oh[v]) begin
        note_d[v] = serve_key;
      end else if (survive[v]) begin
        // New rank = survivors younger than v, plus one if a fresh allocation sits above it.
        rank_d[v] = do_alloc ? 3'd1 : 3'd0;
        for (int u = 0; u < NV; u++) begin
          if (u != v && survive[u] && rank_q[u] < rank_q[v]) rank_d[v] = rank_d[v] + 3'd1;
        end
        if (cnt_q[v] == half_of(note_q[v]) - 17'd1) begin
          cnt_d[v] = '0;
          spk_d[v] = ~spk_q[v];
        end else begin
          cnt_d[v] = cnt_q[v] + 17'd1;
          spk_d[v] = spk_q[v];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      key_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      spk_q     <= '0;
      steal_q   <= 1'b0;
      for (int v = 0; v < NV; v++) begin
        note_q[v] <= '0;
        rank_q[v] <= '0;
        cnt_q[v]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      key_q     <= bus.key;
      pending_q <= pending_d;
      active_q  <= active_d;
      spk_q     <= spk_d;
      steal_q   <= steal_d;
      for (int v = 0; v < NV; v++) begin
        note_q[v] <= note_d[v];
        rank_q[v] <= rank_d[v];
        cnt_q[v]  <= cnt_d[v];
      end
    end
  end

  assign bus.speaker      = spk_q;
  assign bus.voice_active = active_q;
  assign bus.steal        = steal_q;

  always_comb begin
    bus.voice_note = '0;
    for (int v = 0; v < NV; v++) bus.voice_note[3*v +: 3] = note_q[v];
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed and random stimulus for voice_allocator, checked against an LRU-queue reference model.
module tb_voice_allocator;
  localparam int          NV = 2;
  localparam int unsigned DS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  voice_allocator_if #(.NUM_VOICES(NV)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .DIV_SHIFT(DS)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tab [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

  // Reference model: voices listed newest-first in lru; tone phase from allocation edge.
  logic [7:0]    m_keyq = '0;
  logic [7:0]    m_pend = '0;
  logic [NV-1:0] m_act  = '0;
  logic          m_steal = 1'b0;
  int            m_note [NV];
  int            m_t0   [NV];
  int            n_edge = 0;
  int            lru [$];

  function automatic void lru_remove(input int v);
    for (int i = 0; i < lru.size(); i++) begin
      if (lru[i] == v) begin
        lru.delete(i);
        break;
      end
    end
  endfunction

  task automatic model_edge(input logic [7:0] k, input logic r);
    logic [7:0] rel, prs, npend;
    int srv, ch;
    n_edge++;
    m_steal = 1'b0;
    if (r) begin
      m_keyq = '0;
      m_pend = '0;
      m_act  = '0;
      lru.delete();
      for (int v = 0; v < NV; v++) begin
        m_note[v] = 0;
        m_t0[v]   = 0;
      end
      return;
    end
    rel = m_keyq & ~k;
    prs = k & ~m_keyq;
    srv = -1;
    for (int i = 0; i < 8; i++) if (m_pend[i] && srv < 0) srv = i;
    npend = (m_pend | prs) & ~rel;
    if (srv >= 0) npend[srv] = 1'b0;
    ch = -1;
    if (srv >= 0 && !rel[srv]) begin
      for (int v = 0; v < NV; v++) if (!m_act[v] && ch < 0) ch = v;
      if (ch < 0) begin
        ch      = lru[lru.size() - 1];
        m_steal = 1'b1;
      end
    end
    for (int v = 0; v < NV; v++) begin
      if (m_act[v] && rel[m_note[v]] && v != ch) begin
        m_act[v] = 1'b0;
        lru_remove(v);
      end
    end
    if (ch >= 0) begin
      lru_remove(ch);
      lru.push_front(ch);
      m_act[ch]  = 1'b1;
      m_note[ch] = srv;
      m_t0[ch]   = n_edge;
    end
    m_pend = npend;
    m_keyq = k;
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NV-1:0]   es;
    logic [3*NV-1:0] en;
    for (int v = 0; v < NV; v++) begin
      en[3*v +: 3] = 3'(m_note[v]);
      es[v] = m_act[v] ? 1'(((n_edge - m_t0[v]) / (tab[m_note[v]] >> DS)) % 2) : 1'b0;
    end
    expect_eq({tag, "_active"}, 32'(bus.voice_active), 32'(m_act));
    expect_eq({tag, "_note"},   32'(bus.voice_note),   32'(en));
    expect_eq({tag, "_speaker"}, 32'(bus.speaker),     32'(es));
    expect_eq({tag, "_steal"},  32'(bus.steal),        32'(m_steal));
  endtask

  task automatic tick(input logic [7:0] k, input logic r, input string tag);
    bus.key = k;
    rst     = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [7:0] kv;
    logic       rr;
    bus.key = '0;
    for (int v = 0; v < NV; v++) begin
      m_note[v] = 0;
      m_t0[v]   = 0;
    end

    tick(8'h00, 1'b1, "rst");
    tick(8'h00, 1'b1, "rst");
    expect_eq("rst_active", 32'(bus.voice_active), 32'h0);
    expect_eq("rst_note",   32'(bus.voice_note),   32'h0);
    expect_eq("rst_spk",    32'(bus.speaker),      32'h0);

    // Single press: pending at E0, voice at E1, toggle every 93 cycles.
    tick(8'h01, 1'b0, "t1_e0");
    expect_eq("t1_e0_active", 32'(bus.voice_active), 32'h0);
    tick(8'h01, 1'b0, "t1_e1");
    expect_eq("t1_e1_active", 32'(bus.voice_active), 32'h1);
    repeat (92) tick(8'h01, 1'b0, "t1_hold");
    expect_eq("t1_spk_pre", 32'(bus.speaker[0]), 32'h0);
    tick(8'h01, 1'b0, "t1_tog");
    expect_eq("t1_spk_tog", 32'(bus.speaker[0]), 32'h1);

    // Two simultaneous presses.
    tick(8'h00, 1'b1, "t2_rst");
    tick(8'h05, 1'b0, "t2_e0");
    tick(8'h05, 1'b0, "t2_e1");
    expect_eq("t2_e1_active", 32'(bus.voice_active), 32'h1);
    tick(8'h05, 1'b0, "t2_e2");
    expect_eq("t2_e2_active", 32'(bus.voice_active), 32'h3);
    expect_eq("t2_e2_note",   32'(bus.voice_note),   32'h10);
    expect_eq("t2_e2_steal",  32'(bus.steal),        32'h0);

    // Third key steals the oldest voice (voice0).
    repeat (10) tick(8'h05, 1'b0, "t3_hold");
    tick(8'h15, 1'b0, "t3_e0");
    tick(8'h15, 1'b0, "t3_e1");
    expect_eq("t3_note",  32'(bus.voice_note), 32'h14);
    expect_eq("t3_steal", 32'(bus.steal),      32'h1);
    tick(8'h15, 1'b0, "t3_e2");
    expect_eq("t3_steal_end", 32'(bus.steal), 32'h0);

    // Release E4, then A4 reuses voice1.
    tick(8'h11, 1'b0, "t4_rel");
    expect_eq("t4_active", 32'(bus.voice_active), 32'h1);
    expect_eq("t4_spk1",   32'(bus.speaker[1]),   32'h0);
    tick(8'h31, 1'b0, "t4_e0");
    tick(8'h31, 1'b0, "t4_e1");
    expect_eq("t4_note", 32'(bus.voice_note), 32'h2c);
    repeat (54) tick(8'h31, 1'b0, "t4_hold");
    expect_eq("t4_spk_pre", 32'(bus.speaker[1]), 32'h0);
    tick(8'h31, 1'b0, "t4_tog");
    expect_eq("t4_spk_tog", 32'(bus.speaker[1]), 32'h1);

    // One-edge key: release coincides with allocation.
    tick(8'h00, 1'b1, "t5_rst");
    tick(8'h01, 1'b0, "t5_e0");
    tick(8'h00, 1'b0, "t5_e1");
    expect_eq("t5_active", 32'(bus.voice_active), 32'h0);
    expect_eq("t5_steal",  32'(bus.steal),        32'h0);
    repeat (3) tick(8'h00, 1'b0, "t5_idle");
    expect_eq("t5_idle_active", 32'(bus.voice_active), 32'h0);

    // Reset mid-tone with keys held.
    repeat (3) tick(8'h03, 1'b0, "t6_alloc");
    expect_eq("t6_active", 32'(bus.voice_active), 32'h3);
    repeat (20) tick(8'h03, 1'b0, "t6_hold");
    tick(8'h03, 1'b1, "t6_rst");
    expect_eq("t6_rst_active", 32'(bus.voice_active), 32'h0);
    expect_eq("t6_rst_spk",    32'(bus.speaker),      32'h0);
    expect_eq("t6_rst_note",   32'(bus.voice_note),   32'h0);
    tick(8'h03, 1'b0, "t6_e0");
    tick(8'h03, 1'b0, "t6_e1");
    expect_eq("t6_e1_active", 32'(bus.voice_active), 32'h1);
    tick(8'h03, 1'b0, "t6_e2");
    expect_eq("t6_e2_note", 32'(bus.voice_note), 32'h08);

    // Random key activity with occasional resets.
    kv = 8'h03;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) kv[$urandom_range(0, 7)] = ~kv[$urandom_range(0, 7)];
      if ($urandom_range(0, 29) == 0) kv = 8'($urandom);
      rr = ($urandom_range(0, 599) == 0);
      tick(kv, rr, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
